life_cell_gen: RTL and testbench

Parametrised Game-of-Life cell engine for the cell array. It counts a configurable number of neighbour inputs and applies a runtime-programmable birth/survive rule (B/S masks), so Conway, HighLife and similar rules run without a rebuild. An optional multi-state "Generations" refractory decay and a saturating per-cell age counter are supported. One instance sits at each grid site; the array controller drives `ena` and `load` to all cells in common.

---
 rtl/life_cell_gen.sv | 142 ++++++++++++++
 tb/tb_life_cell_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/life_cell_gen.sv
// life_cell_gen: one Game-of-Life site with runtime B/S rule masks,
// optional Generations refractory states and an optional age counter.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   ena          advance one generation
//   load         synchronous load of state_0 (wins over ena)
//   state_0      load value: 1 alive, 0 dead
//   neighbors    alive flags of the neighbour cells
//   birth_mask   bit k: dead cell with k live neighbours is born
//   survive_mask bit k: alive cell with k live neighbours survives
//   state_q      registered cell state (0 dead, 1 alive, >=2 refractory)
//   alive        state_q == 1
//   state_d      combinational next state assuming ena (debug)
//   born         registered pulse on a 0->1 step
//   died         registered pulse on a 1->non-1 step
//   age          generations survived since birth
//
// Build option: define LIFE_CELL_AGE_EN to build the age counter;
// otherwise age is tied to zero.

module life_cell_gen #(
    parameter int N_NEIGHBORS = 8,
    parameter int N_STATES    = 2,
    parameter int AGE_W       = 8,
    localparam int CW = $clog2(N_NEIGHBORS + 1),
    localparam int SW = (N_STATES > 2) ? $clog2(N_STATES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   load,
    input  logic                   state_0,
    input  logic [N_NEIGHBORS-1:0] neighbors,
    input  logic [N_NEIGHBORS:0]   birth_mask,
    input  logic [N_NEIGHBORS:0]   survive_mask,
    output logic [SW-1:0]          state_q,
    output logic                   alive,
    output logic [SW-1:0]          state_d,
    output logic                   born,
    output logic                   died,
    output logic [AGE_W-1:0]       age
);

    localparam logic [SW-1:0] S_DEAD  = SW'(0);
    localparam logic [SW-1:0] S_ALIVE = SW'(1);
    localparam logic [SW-1:0] S_REFR  = SW'(2);
    localparam logic [SW-1:0] S_LAST  = SW'(N_STATES - 1);

    logic [SW-1:0] r_state;
    logic          r_born;
    logic          r_died;
    logic [CW-1:0] w_count;
    logic [SW-1:0] w_state_d;
    logic          w_born_ev;
    logic          w_died_ev;

    // Population count of the live neighbours.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < N_NEIGHBORS; i++) begin
            w_count = w_count + CW'(neighbors[i]);
        end
    end

    // Next-state rule. Refractory states ignore neighbours and
    // march towards dead; anything at or past the last state wraps.
    always_comb begin
        w_state_d = S_DEAD;
        if (r_state == S_DEAD) begin
            w_state_d = birth_mask[w_count] ? S_ALIVE : S_DEAD;
        end else if (r_state == S_ALIVE) begin
            if (survive_mask[w_count]) begin
                w_state_d = S_ALIVE;
            end else if (N_STATES == 2) begin
                w_state_d = S_DEAD;
            end else begin
                w_state_d = S_REFR;
            end
        end else if (r_state >= S_LAST) begin
            w_state_d = S_DEAD;
        end else begin
            w_state_d = r_state + S_ALIVE;
        end
    end

    assign w_born_ev = (r_state == S_DEAD) && (w_state_d == S_ALIVE);
    assign w_died_ev = (r_state == S_ALIVE) && (w_state_d != S_ALIVE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_DEAD;
            r_born  <= 1'b0;
            r_died  <= 1'b0;
        end else if (load) begin
            r_state <= state_0 ? S_ALIVE : S_DEAD;
            r_born  <= 1'b0;
            r_died  <= 1'b0;
        end else if (ena) begin
            r_state <= w_state_d;
            r_born  <= w_born_ev;
            r_died  <= w_died_ev;
        end else begin
            r_born  <= 1'b0;
            r_died  <= 1'b0;
        end
    end

`ifdef LIFE_CELL_AGE_EN
    logic [AGE_W-1:0] r_age;

    // Only an alive->alive step counts; birth, death and every
    // non-alive step leave the counter at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_age <= '0;
        end else if (load) begin
            r_age <= '0;
        end else if (ena) begin
            if (r_state == S_ALIVE && w_state_d == S_ALIVE) begin
                if (r_age != {AGE_W{1'b1}}) begin
                    r_age <= r_age + AGE_W'(1);
                end
            end else begin
                r_age <= '0;
            end
        end
    end

    assign age = r_age;
`else
    assign age = '0;
`endif

    assign state_q = r_state;
    assign alive   = (r_state == S_ALIVE);
    assign state_d = w_state_d;
    assign born    = r_born;
    assign died    = r_died;

endmodule

// File: tb/tb_life_cell_gen.sv
// Directed bench for life_cell_gen: Conway, Generations, age,
// reduced neighbourhood, hold, load priority and async reset.

module tb_life_cell_gen;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    logic load;
    logic state_0;

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Conway instance
    logic [7:0] cw_nb;
    logic [0:0] cw_q, cw_d;
    logic cw_alive, cw_born, cw_died;
    logic [7:0] cw_age;

    // Generations instance (4 states)
    logic [7:0] gn_nb;
    logic [1:0] gn_q, gn_d;
    logic gn_alive, gn_born, gn_died;
    logic [7:0] gn_age;

    // Age instance (AGE_W=2)
    logic [7:0] ag_nb;
    logic [0:0] ag_q, ag_d;
    logic ag_alive, ag_born, ag_died;
    logic [1:0] ag_age;

    // Reduced neighbourhood instance (4 neighbours)
    logic [3:0] rd_nb;
    logic [0:0] rd_q, rd_d;
    logic rd_alive, rd_born, rd_died;
    logic [7:0] rd_age;

    logic [8:0] bm8 = 9'h008;
    logic [8:0] sm8 = 9'h00C;
    logic [4:0] bm4 = 5'b10000;
    logic [4:0] sm4 = 5'b00000;

    life_cell_gen #(.N_NEIGHBORS(8), .N_STATES(2), .AGE_W(8)) u_cw (
        .clk(clk), .rst(rst), .ena(ena), .load(load), .state_0(state_0),
        .neighbors(cw_nb), .birth_mask(bm8), .survive_mask(sm8),
        .state_q(cw_q), .alive(cw_alive), .state_d(cw_d),
        .born(cw_born), .died(cw_died), .age(cw_age)
    );

    life_cell_gen #(.N_NEIGHBORS(8), .N_STATES(4), .AGE_W(8)) u_gn (
        .clk(clk), .rst(rst), .ena(ena), .load(load), .state_0(state_0),
        .neighbors(gn_nb), .birth_mask(bm8), .survive_mask(sm8),
        .state_q(gn_q), .alive(gn_alive), .state_d(gn_d),
        .born(gn_born), .died(gn_died), .age(gn_age)
    );

    life_cell_gen #(.N_NEIGHBORS(8), .N_STATES(2), .AGE_W(2)) u_ag (
        .clk(clk), .rst(rst), .ena(ena), .load(load), .state_0(state_0),
        .neighbors(ag_nb), .birth_mask(bm8), .survive_mask(sm8),
        .state_q(ag_q), .alive(ag_alive), .state_d(ag_d),
        .born(ag_born), .died(ag_died), .age(ag_age)
    );

    life_cell_gen #(.N_NEIGHBORS(4), .N_STATES(2), .AGE_W(8)) u_rd (
        .clk(clk), .rst(rst), .ena(ena), .load(load), .state_0(state_0),
        .neighbors(rd_nb), .birth_mask(bm4), .survive_mask(sm4),
        .state_q(rd_q), .alive(rd_alive), .state_d(rd_d),
        .born(rd_born), .died(rd_died), .age(rd_age)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected age: counter only exists with the build option.
    function automatic logic [31:0] xa(input int v);
`ifdef LIFE_CELL_AGE_EN
        return 32'(v);
`else
        return 32'(v * 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; ena = 1'b0; load = 1'b0; state_0 = 1'b0;
        cw_nb = '0; gn_nb = '0; ag_nb = '0; rd_nb = '0;
        #1;
        chk("rst_state", 32'(cw_q), 0);
        chk("rst_alive", 32'(cw_alive), 0);
        chk("rst_born", 32'(cw_born), 0);
        chk("rst_died", 32'(cw_died), 0);
        chk("rst_age", 32'(cw_age), 0);
        #20 rst = 1'b1;

        // Conway birth then overcrowding death
        cw_nb = 8'b0000_0111;
        ena = 1'b1;
        #1;
        chk("cw_d_birth", 32'(cw_d), 1);
        tick();
        chk("cw_q_born", 32'(cw_q), 1);
        chk("cw_alive", 32'(cw_alive), 1);
        chk("cw_born", 32'(cw_born), 1);
        chk("cw_died0", 32'(cw_died), 0);
        cw_nb = 8'b0000_1111;
        #1;
        chk("cw_d_over", 32'(cw_d), 0);
        tick();
        chk("cw_q_dead", 32'(cw_q), 0);
        chk("cw_died", 32'(cw_died), 1);
        chk("cw_born0", 32'(cw_born), 0);

        // load wins over ena; ena alone would have caused a birth
        cw_nb = 8'b0000_0111;
        load = 1'b1; state_0 = 1'b1;
        tick();
        load = 1'b0; state_0 = 1'b0;
        chk("ld_cw_q", 32'(cw_q), 1);
        chk("ld_cw_born", 32'(cw_born), 0);
        chk("ld_cw_died", 32'(cw_died), 0);
        chk("ld_cw_age", 32'(cw_age), 0);
        chk("ld_gn_q", 32'(gn_q), 1);
        chk("ld_ag_age", 32'(ag_age), 0);

        // S1: alive cells with no neighbours
        cw_nb = 8'b0000_0011;
        gn_nb = '0; ag_nb = '0; rd_nb = '0;
        #1;
        chk("gn_d_refr", 32'(gn_d), 2);
        tick();
        chk("s1_gn_q", 32'(gn_q), 2);
        chk("s1_gn_died", 32'(gn_died), 1);
        chk("s1_gn_alive", 32'(gn_alive), 0);
        chk("s1_ag_q", 32'(ag_q), 0);
        chk("s1_ag_age", 32'(ag_age), 0);
        chk("s1_rd_q", 32'(rd_q), 0);
        chk("s1_rd_died", 32'(rd_died), 1);
        chk("s1_cw_q", 32'(cw_q), 1);
        chk("s1_cw_age", 32'(cw_age), xa(1));

        // S2: 3 neighbours during refractory; birth in age cell
        gn_nb = 8'b0000_0111;
        ag_nb = 8'b0000_0111;
        rd_nb = 4'b0111;
        tick();
        chk("s2_gn_q", 32'(gn_q), 3);
        chk("s2_gn_born", 32'(gn_born), 0);
        chk("s2_gn_died", 32'(gn_died), 0);
        chk("s2_ag_born", 32'(ag_born), 1);
        chk("s2_ag_age", 32'(ag_age), 0);
        chk("s2_rd_q", 32'(rd_q), 0);
        chk("s2_rd_born", 32'(rd_born), 0);

        // S3: wrap to dead; reduced array full neighbourhood
        ag_nb = 8'b0000_0011;
        rd_nb = 4'b1111;
        tick();
        chk("s3_gn_q", 32'(gn_q), 0);
        chk("s3_gn_born", 32'(gn_born), 0);
        chk("s3_ag_age", 32'(ag_age), xa(1));
        chk("s3_ag_born", 32'(ag_born), 0);
        chk("s3_rd_q", 32'(rd_q), 1);
        chk("s3_rd_born", 32'(rd_born), 1);

        // S4..S7: dead gen cell born again; age saturates
        tick();
        chk("s4_gn_q", 32'(gn_q), 1);
        chk("s4_gn_born", 32'(gn_born), 1);
        chk("s4_ag_age", 32'(ag_age), xa(2));
        tick();
        chk("s5_ag_age", 32'(ag_age), xa(3));
        tick();
        chk("s6_ag_age", 32'(ag_age), xa(3));
        tick();
        chk("s7_ag_age", 32'(ag_age), xa(3));
        chk("s7_ag_q", 32'(ag_q), 1);

        // Hold for 5 cycles
        ena = 1'b0;
        ag_nb = 8'b0000_1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_ag_q", 32'(ag_q), 1);
            chk("hold_ag_age", 32'(ag_age), xa(3));
            chk("hold_ag_died", 32'(ag_died), 0);
            chk("hold_gn_born", 32'(gn_born), 0);
        end

        // Conway death pulse, then async reset mid-cycle
        cw_nb = 8'b0000_1111;
        ag_nb = 8'b0000_0011;
        ena = 1'b1;
        tick();
        ena = 1'b0;
        chk("pre_cw_died", 32'(cw_died), 1);
        chk("pre_ag_age", 32'(ag_age), xa(3));
        #2 rst = 1'b0;
        #1;
        chk("ar_cw_died", 32'(cw_died), 0);
        chk("ar_ag_q", 32'(ag_q), 0);
        chk("ar_ag_alive", 32'(ag_alive), 0);
        chk("ar_ag_age", 32'(ag_age), 0);
        chk("ar_gn_q", 32'(gn_q), 0);
        rst = 1'b1;
        cw_nb = '0;
        ena = 1'b1;
        tick();
        tick();
        chk("post_cw_q", 32'(cw_q), 0);
        chk("post_ag_q", 32'(ag_q), 1'b0);
        chk("post_cw_born", 32'(cw_born), 0);
        ena = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
